key_expansion_ctrl: RTL
=======================

Name: key_expansion_ctrl

Overview:
Iterative AES-128 key-schedule controller. It loads a cipher key and produces the 11 round keys (rounds 0..10) one per handshake, using a single shared subWord datapath (four S-boxes) per round. It sits between the key-load interface and the round datapath, which consumes round keys via a valid/ready handshake.

Parameters:
NUM_ROUNDS, 10, number of expansion rounds; only 10 is legal (AES-128); an elaboration-time assertion rejects any other value.

Ports:
Clk_CI  input  1  clock; all state updates on the rising edge.
Rst_RBI  input  1  asynchronous active-low reset.
Start_SI  input  1  load Key_DI and begin expansion; honoured only in IDLE.
Key_DI  input  128  cipher key; w0 = [127:96], byte 0 of each word = MSB byte (FIPS-197 order).
Clear_SI  input  1  synchronous abort; returns to IDLE from any state.
RoundKey_DO  output  128  current round key (registered).
Round_DO  output  4  index of the round key on RoundKey_DO (0..10).
Valid_SO  output  1  RoundKey_DO/Round_DO valid.
Ready_SI  input  1  consumer accepts the current round key.
Busy_SO  output  1  high in any state other than IDLE.
Done_SO  output  1  one-cycle pulse after round 10 is accepted.

Behaviour:
- Reset (async assert): state IDLE, RoundKey_DO=0, Round_DO=0, Rcon register=8'h01, Valid_SO=0, Busy_SO=0, Done_SO=0. Deassertion is synchronised externally.
- FSM states: IDLE, VALID, DONE.
- IDLE: Start_SI=1 -> register Key_DI into RoundKey_DO, Round_DO=0, Rcon=01, go to VALID. Valid_SO rises the cycle after Start (latency 1).
- VALID: Valid_SO=1. RoundKey_DO and Round_DO hold while Ready_SI=0.
  - On Ready_SI=1 with Round_DO<10: load the next key, Round_DO+1, Rcon=xtime(Rcon), stay in VALID. The next key is valid the following cycle, so throughput is one key per cycle with Ready held high.
  - On Ready_SI=1 with Round_DO=10: go to DONE.
- DONE: Done_SO=1 for exactly one cycle, Valid_SO=0, then IDLE. RoundKey_DO keeps the round-10 key.
- Next-key arithmetic (combinational from RoundKey_DO = w0..w3):
  - t = subWord(RotWord(w3)) XOR {Rcon,24'h0}, where RotWord([a0,a1,a2,a3]) = [a1,a2,a3,a0].
  - n0 = w0^t, n1 = w1^n0, n2 = w2^n1, n3 = w3^n2.
- Rcon sequence over rounds 1..10: 01,02,04,08,10,20,40,80,1B,36. xtime = left shift, XOR 1B if MSB set, 8-bit wrap.
- Start_SI in VALID or DONE: ignored, with no restart and no corruption.
- Start_SI and Ready_SI in the same cycle in VALID: the Ready handling applies and Start is ignored.
- Clear_SI has priority over all other inputs: next state IDLE, Valid_SO=0, Round_DO=0, Rcon=01, no Done pulse. RoundKey_DO is cleared to 0.
- Clear_SI and Start_SI together in IDLE: Clear wins and nothing is loaded.
- Async reset mid-expansion: immediate return to reset values.
- Ready_SI while Valid_SO=0: ignored.

Decomposition:
- Shared package gets:
  - Byte and Word typedefs (already in use).
  - RoundKey typedef as a 128-bit vector.
  - NUM_ROUNDS_AES128=10 and RCON_INIT=8'h01 constants.
  - xtime function.
  - rotWord function.
  - keyExpState_t enum {IDLE, VALID, DONE}.
- One sub-module: the existing subWord, instantiated once on RotWord(w3).
- FSM, Rcon register and round counter are inline.

Test Plan:
1. Reset, then Start with Key_DI=2b7e151628aed2a6abf7158809cf4f3c and Ready_SI=1 -> Round 0 key = input; Round 1 = a0fafe1788542cb123a339392a6c7605; Round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6; Done_SO pulses 12 cycles after Start.
2. Same key with Ready_SI low for 3 cycles during round 4 -> RoundKey_DO and Round_DO stable while stalled; final round-10 key unchanged from scenario 1.
3. Clear_SI asserted at Round_DO=5 -> next cycle IDLE, Valid_SO=0, Busy_SO=0, no Done pulse. A new Start then yields the correct round 1 key (Rcon restarted at 01).
4. Start_SI pulsed at Round_DO=3 with a different key -> ignored; the sequence completes with the original keys.
5. Key_DI=000...0 -> Round 1 = 62636363626363636263636362636363 and Round 10 = b4ef5bcb3e92e21123e951cf6f8f188e, exercising the Rcon wrap to 1B/36.
6. Rst_RBI asserted asynchronously at Round_DO=7 mid-cycle -> all outputs at reset values immediately, before the next clock edge.

Source files
------------

// File: rtl/key_expansion_ctrl_pkg.sv
// Shared types, constants and helper functions for the AES-128 key-schedule controller.
package key_expansion_ctrl_pkg;

  typedef logic [7:0]   byte_t;
  typedef logic [31:0]  word_t;
  typedef logic [127:0] round_key_t;

  localparam int    NUM_ROUNDS_AES128 = 10;
  localparam byte_t RCON_INIT         = 8'h01;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    VALID = 2'd1,
    DONE  = 2'd2
  } key_exp_state_t;

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // [a0,a1,a2,a3] -> [a1,a2,a3,a0], a0 being the most significant byte.
  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/key_expansion_ctrl_subword.sv
// subWord: four parallel AES S-box lookups, one per byte lane of the word.
module key_expansion_ctrl_subword
  import key_expansion_ctrl_pkg::*;
(
  input  word_t i_word,
  output word_t o_word
);

  // Forward S-box flattened row-major; entry 0 sits in the top byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
      logic [10:0] w_bit_hi;
      assign w_bit_hi = 11'd2047 - {i_word[8*gi +: 8], 3'b000};
      assign o_word[8*gi +: 8] = SBOX_TABLE[w_bit_hi -: 8];
    end
  endgenerate

endmodule

// File: rtl/key_expansion_ctrl.sv
// Iterative AES-128 key-schedule controller: emits round keys 0..10 over a valid/ready handshake.
module key_expansion_ctrl
  import key_expansion_ctrl_pkg::*;
#(
  parameter int NUM_ROUNDS = NUM_ROUNDS_AES128
) (
  input  logic         Clk_CI,
  input  logic         Rst_RBI,
  input  logic         Start_SI,
  input  logic [127:0] Key_DI,
  input  logic         Clear_SI,
  output logic [127:0] RoundKey_DO,
  output logic [3:0]   Round_DO,
  output logic         Valid_SO,
  input  logic         Ready_SI,
  output logic         Busy_SO,
  output logic         Done_SO
);

  generate
    if (NUM_ROUNDS != NUM_ROUNDS_AES128) begin : g_bad_rounds
      $error("key_expansion_ctrl: NUM_ROUNDS must be 10 (AES-128)");
    end
  endgenerate

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  key_exp_state_t r_state, w_state_next;
  round_key_t     r_round_key, w_round_key_next;
  logic [3:0]     r_round, w_round_next;
  byte_t          r_rcon, w_rcon_next;

  word_t      w_w0, w_w1, w_w2, w_w3;
  word_t      w_rot, w_sub, w_t;
  word_t      w_n0, w_n1, w_n2, w_n3;
  round_key_t w_next_key;

  assign w_w0  = r_round_key[127:96];
  assign w_w1  = r_round_key[95:64];
  assign w_w2  = r_round_key[63:32];
  assign w_w3  = r_round_key[31:0];
  assign w_rot = rot_word(w_w3);

  key_expansion_ctrl_subword u_subword (
    .i_word (w_rot),
    .o_word (w_sub)
  );

  assign w_t        = w_sub ^ {r_rcon, 24'h000000};
  assign w_n0       = w_w0 ^ w_t;
  assign w_n1       = w_w1 ^ w_n0;
  assign w_n2       = w_w2 ^ w_n1;
  assign w_n3       = w_w3 ^ w_n2;
  assign w_next_key = {w_n0, w_n1, w_n2, w_n3};

  always_comb begin
    w_state_next     = r_state;
    w_round_key_next = r_round_key;
    w_round_next     = r_round;
    w_rcon_next      = r_rcon;

    case (r_state)
      IDLE: begin
        if (Start_SI) begin
          w_round_key_next = Key_DI;
          w_round_next     = 4'd0;
          w_rcon_next      = RCON_INIT;
          w_state_next     = VALID;
        end
      end
      VALID: begin
        // Start is deliberately not looked at here; only the handshake advances.
        if (Ready_SI) begin
          if (r_round == LAST_ROUND) begin
            w_state_next = DONE;
          end else begin
            w_round_key_next = w_next_key;
            w_round_next     = r_round + 4'd1;
            w_rcon_next      = xtime(r_rcon);
          end
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase

    if (Clear_SI) begin
      w_state_next     = IDLE;
      w_round_key_next = '0;
      w_round_next     = 4'd0;
      w_rcon_next      = RCON_INIT;
    end
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      r_state     <= IDLE;
      r_round_key <= '0;
      r_round     <= 4'd0;
      r_rcon      <= RCON_INIT;
    end else begin
      r_state     <= w_state_next;
      r_round_key <= w_round_key_next;
      r_round     <= w_round_next;
      r_rcon      <= w_rcon_next;
    end
  end

  assign RoundKey_DO = r_round_key;
  assign Round_DO    = r_round;
  assign Valid_SO    = (r_state == VALID);
  assign Busy_SO     = (r_state != IDLE);
  assign Done_SO     = (r_state == DONE);

endmodule
